// File: rtl/oldland_prefetch.sv
// oldland_prefetch: instruction prefetch stage with a FIFO_DEPTH-entry queue
// between the req/ack instruction bus and decode. One bus request may be
// outstanding. A branch redirect flushes the queue, and a request already in
// flight when the branch arrives is completed and its data discarded.
// Loads, stores and branches (instr[31:30] = 01 or 10) stall delivery until
// stall_clear arrives.
//
// Optional build macro OLDLAND_FETCH_BYPASS_EN: when the queue is empty and
// fetch is not stalled, an acked word goes straight to decode in the same
// cycle instead of being queued.
module oldland_prefetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_req,
    input  logic                  i_ack,
    input  logic [31:0]           i_data,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_pc,
    input  logic                  stall_clear,
    output logic                  stalling,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus_4
);

    localparam int          PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

    // Queue storage: fetched address and instruction word per entry.
    logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
    logic [31:0]           data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]      head_reg, tail_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [ADDR_WIDTH-1:0] fetch_addr_reg;
    logic [ADDR_WIDTH-1:0] i_addr_reg;
    logic                  i_req_reg;
    logic                  drop_pending_reg;
    logic                  stalled_reg;
    logic [ADDR_WIDTH-1:0] pc_reg;

    logic                  acked;
    logic                  take;
    logic                  queue_empty;
    logic                  bypass;
    logic                  pop;
    logic                  push;
    logic                  deliver;
    logic                  mem_class;
    logic                  stall_pop;
    logic                  hold_req;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [31:0]           out_data;
    logic [CNT_W-1:0]      count_next;
    logic [ADDR_WIDTH-1:0] fetch_next;

    // Handshake decode, queue head selection and decode-side outputs.
    always_comb begin
        acked       = i_req_reg & i_ack;
        take        = acked & ~drop_pending_reg;
        queue_empty = (count_reg == '0);
`ifdef OLDLAND_FETCH_BYPASS_EN
        bypass      = ~rst & take & queue_empty & ~stalled_reg & ~branch_taken;
`else
        bypass      = 1'b0;
`endif
        pop         = ~rst & ~branch_taken & ~stalled_reg & ~queue_empty;
        push        = take & ~bypass & ~branch_taken;
        deliver     = pop | bypass;
        hold_req    = i_req_reg & ~i_ack;
        out_addr    = bypass ? i_addr_reg : addr_mem[head_reg];
        out_data    = bypass ? i_data     : data_mem[head_reg];
        mem_class   = (out_data[31:30] == 2'b01) || (out_data[31:30] == 2'b10);
        stall_pop   = deliver & mem_class;
        count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
        fetch_next  = take ? (i_addr_reg + ADDR_WIDTH'(4)) : fetch_addr_reg;

        instr_valid = deliver;
        instr       = deliver ? out_data : INSTR_NOP;
        pc          = deliver ? out_addr : pc_reg;
        pc_plus_4   = pc + ADDR_WIDTH'(4);
        stalling    = ~rst & (stalled_reg | stall_pop) & ~stall_clear;
        i_req       = i_req_reg;
        i_addr      = i_addr_reg;
    end

    // Queue write port; contents need no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= i_addr_reg;
            data_mem[tail_reg] <= i_data;
        end
    end

    // Control state: pointers, bus request, drop tracking, stall and last pc.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
            fetch_addr_reg   <= RESET_PC;
            i_addr_reg       <= RESET_PC;
            i_req_reg        <= 1'b0;
            drop_pending_reg <= 1'b0;
            stalled_reg      <= 1'b0;
            pc_reg           <= RESET_PC;
        end else begin
            if (deliver) begin
                pc_reg <= out_addr;
            end
            if (branch_taken) begin
                // Redirect wins over everything; an unacked request in flight
                // keeps the bus until it completes and is then thrown away.
                head_reg         <= '0;
                tail_reg         <= '0;
                count_reg        <= '0;
                fetch_addr_reg   <= branch_pc;
                stalled_reg      <= 1'b0;
                drop_pending_reg <= hold_req;
                if (!hold_req) begin
                    i_req_reg  <= 1'b1;
                    i_addr_reg <= branch_pc;
                end
            end else begin
                if (push) begin
                    tail_reg <= tail_reg + PTR_W'(1);
                end
                if (pop) begin
                    head_reg <= head_reg + PTR_W'(1);
                end
                count_reg      <= count_next;
                fetch_addr_reg <= fetch_next;
                if (acked && drop_pending_reg) begin
                    drop_pending_reg <= 1'b0;
                end
                stalled_reg <= stall_clear ? 1'b0 : (stalled_reg | stall_pop);
                // A new request is only raised when the queue can absorb its
                // data, which keeps the outstanding slot reserved.
                if (!hold_req) begin
                    i_req_reg  <= (count_next < CNT_W'(FIFO_DEPTH));
                    i_addr_reg <= fetch_next;
                end
            end
        end
    end

endmodule

// File: doc/oldland_prefetch.md
Name: oldland_prefetch

Overview:
Parametrised successor to the single-entry fetch stage. It decouples instruction memory from decode through a FIFO_DEPTH-entry prefetch queue and a req/ack memory port with one request outstanding. It supports branch redirect with queue flush and discard of in-flight data. It keeps the load/store/branch stall-and-NOP scheme and sits between the instruction bus and the decode stage.

Parameters:
ADDR_WIDTH, 32, width of PC and fetch addresses; bits [1:0] always 0.
FIFO_DEPTH, 4, prefetch queue entries; power of two, 2..16.
RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_addr  out  ADDR_WIDTH  instruction fetch address, word aligned
i_req  out  1  fetch request; held with stable i_addr until i_ack
i_ack  in  1  request complete; i_data valid this cycle
i_data  in  32  fetched instruction word
branch_taken  in  1  one-cycle redirect strobe
branch_pc  in  ADDR_WIDTH  redirect target
stall_clear  in  1  later stage releases fetch stall
stalling  out  1  fetch is stalled
instr_valid  out  1  instr/pc valid and consumed this cycle
instr  out  32  instruction to decode; INSTR_NOP when not valid
pc  out  ADDR_WIDTH  address of instr
pc_plus_4  out  ADDR_WIDTH  pc + 4, wraps mod 2^ADDR_WIDTH

Behaviour:
- Reset (sync, rst=1): queue empty, fetch_addr=RESET_PC, i_req=0, drop_pending=0, stalled=0. Outputs: instr_valid=0, instr=INSTR_NOP, pc=RESET_PC, stalling=0.
- Memory side: i_req=1 when (count + outstanding) < FIFO_DEPTH and not drop-only. Once raised, i_req and i_addr hold until i_ack.
- Ack handling: on i_ack with drop_pending=0, push {i_addr, i_data} and set fetch_addr=i_addr+4. On i_ack with drop_pending=1, discard data and clear drop_pending.
- Queue pop: pop when count>0 and stalled=0. That cycle instr_valid=1 and instr/pc come from the head. Push and pop may occur in the same cycle; count is unchanged.
- Full: no request is issued. The outstanding slot is reserved, so an ack never overflows the queue.
- Empty: instr_valid=0, instr=INSTR_NOP, pc holds its last value.
- Stall: if the popped instr[31:30] is 01 or 10 (load/store/branch), stalled=1 from the next cycle. While stalled, pop is inhibited, instr_valid=0 and instr=INSTR_NOP. Prefetch continues until the queue is full.
- Stall outputs: stalling = (stalled | popping class 01/10) & !stall_clear. stall_clear clears stalled the next cycle. If stall_clear coincides with a class-01/10 pop, stalled stays 0.
- Redirect: branch_taken has priority over push, pop and stall. Same cycle: queue flushed, fetch_addr=branch_pc, stalled=0, and no pop (instr_valid=0). Next cycle: i_req to branch_pc unless drop-only applies.
- Outstanding at redirect: if a request is outstanding and not acked in the redirect cycle, set drop_pending=1. The held request completes and is discarded, then i_addr=branch_pc. If acked in the same cycle, that data is discarded directly and drop_pending stays 0.
- Back-to-back branch_taken: the last target wins. drop_pending is never more than 1.
- Address wrap: fetch_addr+4 wraps modulo 2^ADDR_WIDTH with no special handling.
- Latency: ack into an empty queue gives instr_valid=1 on the next cycle (1-cycle minimum).

Optional Feature:
OLDLAND_FETCH_BYPASS_EN
- Defined: when the queue is empty, stalled=0 and a non-dropped i_ack arrives, i_data/i_addr drive instr/pc combinationally with instr_valid=1 that cycle, and nothing is pushed. Stall detection applies to bypassed words as well. Latency is 0 cycles.
- Undefined: all data passes through the queue; latency is 1 cycle.

Test Plan:
- Reset then stream: rst for 2 cycles, i_ack every cycle with i_data=0x00000000 (class 00). i_addr goes 0,4,8,... and pc sequence is 0,4,8 with instr_valid=1 every cycle from cycle 2 onward (cycle 1 with BYPASS).
- Fill: hold stall by popping a class-10 word (0x80000000) at pc=0x0 with no stall_clear. Exactly FIFO_DEPTH further words are fetched, then i_req=0. instr=NOP and stalling=1 throughout.
- Stall release: assert stall_clear one cycle. Next cycle stalled=0 and pop resumes at pc=0x4.
- Redirect with outstanding request: i_req=1 at 0x10 with no ack, branch_taken with branch_pc=0x200. Ack next cycle: the 0x10 data is discarded, then i_addr=0x200, and the first valid pc is 0x200.
- Redirect with ack in the same cycle: ack data is dropped, no drop_pending, and the next i_addr=0x200. Also assert a pop in that cycle and confirm instr_valid=0.
- Wrap and stall/clear collision: RESET_PC=32'hfffffffc. First pc is 0xfffffffc with pc_plus_4=0x0, then pc=0x0. A class-01 pop together with stall_clear leaves stalling=0 and no NOP is inserted.
